vec_lsu: RTL

Vector load/store unit moving 256-bit vector registers (v16–v23) to and from 32-bit data memory. Sits between the vector register file and the data memory port. A load assembles eight 32-bit beats and writes the result into the vector register file's write port; a store snapshots a register read operand and streams it out as eight beats. Each transaction uses a request/acknowledge memory handshake and ends with a single-cycle `done` pulse.

---
 rtl/vec_pkg.sv | 19 +
 rtl/vec_beat_buf.sv | 49 ++++
 rtl/vec_lsu.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/vec_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vec_pkg                                                               |
// | Shared constants and FSM state type for the vector load/store unit.   |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
package vec_pkg;
   localparam int         DATA_W    = 32;
   localparam int         VEC_W     = 256;
   localparam int         BEATS     = VEC_W / DATA_W;
   localparam logic [4:0] VREG_BASE = 5'd16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      FIN  = 2'd2
   } vlsu_state_t;
endpackage
`default_nettype wire

// File: rtl/vec_beat_buf.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vec_beat_buf                                                          |
// | Vector-wide staging buffer: whole-vector snapshot, per-beat slice     |
// | write and per-beat slice read. Beat i occupies bits [32i+31:32i].     |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module vec_beat_buf #(
   parameter int DATA_W = vec_pkg::DATA_W,
   parameter int VEC_W  = vec_pkg::VEC_W,
   parameter int IDX_W  = $clog2(VEC_W / DATA_W)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              snap_en,
   input  logic [VEC_W-1:0]  snap_data,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wr_data,
   output logic [VEC_W-1:0]  vec,
   output logic [DATA_W-1:0] rd_data
);

   logic [VEC_W-1:0] data_d, data_q;

   // Snapshot has priority; otherwise a beat write replaces only its own slice.
   always_comb begin
      data_d = data_q;
      if (snap_en) begin
         data_d = snap_data;
      end else if (wr_en) begin
         data_d[int'(idx) * DATA_W +: DATA_W] = wr_data;
      end
   end

   // Buffer register, cleared by the active-low synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign vec     = data_q;
   assign rd_data = data_q[int'(idx) * DATA_W +: DATA_W];

endmodule
`default_nettype wire

// File: rtl/vec_lsu.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | vec_lsu                                                               |
// | Vector load/store unit: moves a 256-bit vector register to/from a     |
// | 32-bit memory port as eight req/ack beats, then pulses done.          |
// | Optional feature macro: VLSU_STRIDE_EN (adds a programmable stride).  |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module vec_lsu #(
   parameter int DATA_W = vec_pkg::DATA_W,
   parameter int VEC_W  = vec_pkg::VEC_W,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              is_store,
   input  logic [ADDR_W-1:0] base_addr,
`ifdef VLSU_STRIDE_EN
   input  logic [ADDR_W-1:0] stride,
`endif
   input  logic [4:0]        vdst,
   input  logic [VEC_W-1:0]  vsrc_data,
   output logic              busy,
   output logic              done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wd,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rd,
   output logic              vwe3,
   output logic [4:0]        vwa3,
   output logic [VEC_W-1:0]  vwd3
);
   import vec_pkg::*;

   localparam int             NBEATS    = VEC_W / DATA_W;
   localparam int             BW        = $clog2(NBEATS);
   localparam logic [BW-1:0]  LAST_BEAT = BW'(NBEATS - 1);

   vlsu_state_t       state_q, state_d;
   logic              store_q, store_d;
   logic [4:0]        vdst_q, vdst_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] stride_q, stride_d;
   logic [BW-1:0]     beat_q, beat_d;
   logic [ADDR_W-1:0] stride_in;
   logic              snap_en;
   logic              slice_we;
   logic [VEC_W-1:0]  buf_vec;
   logic [DATA_W-1:0] buf_slice;

`ifdef VLSU_STRIDE_EN
   assign stride_in = {stride[ADDR_W-1:2], 2'b00};
`else
   assign stride_in = ADDR_W'(DATA_W / 8);
`endif

   vec_beat_buf #(
      .DATA_W (DATA_W),
      .VEC_W  (VEC_W),
      .IDX_W  (BW)
   ) u_beat_buf (
      .clk       (clk),
      .rst       (rst),
      .snap_en   (snap_en),
      .snap_data (vsrc_data),
      .wr_en     (slice_we),
      .idx       (beat_q),
      .wr_data   (mem_rd),
      .vec       (buf_vec),
      .rd_data   (buf_slice)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: start only honoured in IDLE; last acked beat moves to FIN.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = XFER;
         XFER:    if (mem_ack && (beat_q == LAST_BEAT)) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Transaction context: latched at start, address/beat advance on each ack.
   always_comb begin
      store_d  = store_q;
      vdst_d   = vdst_q;
      addr_d   = addr_q;
      stride_d = stride_q;
      beat_d   = beat_q;
      snap_en  = 1'b0;
      slice_we = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               store_d  = is_store;
               vdst_d   = vdst;
               addr_d   = {base_addr[ADDR_W-1:2], 2'b00};
               stride_d = stride_in;
               beat_d   = '0;
               snap_en  = is_store;
            end
         end
         XFER: begin
            if (mem_ack) begin
               slice_we = !store_q;
               beat_d   = beat_q + 1'b1;
               addr_d   = addr_q + stride_q;
            end
         end
         default: ;
      endcase
   end

   // Context registers; a reset mid-transaction drops everything.
   always_ff @(posedge clk) begin
      if (!rst) begin
         store_q  <= 1'b0;
         vdst_q   <= '0;
         addr_q   <= '0;
         stride_q <= '0;
         beat_q   <= '0;
      end else begin
         store_q  <= store_d;
         vdst_q   <= vdst_d;
         addr_q   <= addr_d;
         stride_q <= stride_d;
         beat_q   <= beat_d;
      end
   end

   // Outputs decoded from registered state only, zero outside their phase.
   always_comb begin
      busy     = (state_q != IDLE);
      done     = (state_q == FIN);
      mem_req  = (state_q == XFER);
      mem_we   = (state_q == XFER) && store_q;
      mem_addr = (state_q == XFER) ? addr_q : '0;
      mem_wd   = (state_q == XFER) ? buf_slice : '0;
      vwe3     = (state_q == FIN) && !store_q;
      vwa3     = vwe3 ? vdst_q : '0;
      vwd3     = vwe3 ? buf_vec : '0;
   end

endmodule
`default_nettype wire
